if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC register and drives Address to the combinational instruction ROM; captures the returned Instruction into the IF/ID pipeline register.
- Selects the next PC from sequential, branch (EX), jump/jr (ID), interrupt and exception sources.
- PC[31] is the kernel-mode bit; the ROM decodes only Address[9:2], so PC[31] is transparent to it.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/pc_next_sel.sv | 48 ++++
 rtl/if_fetch_stage.sv | 130 +++++++++++++
 tb/tb_if_fetch_stage.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and next-PC select encoding for the MIPS pipeline front end.
package mips_pkg;

   localparam logic [31:0] RESET_PC   = 32'h8000_0000;
   localparam logic [31:0] IRQ_VECTOR = 32'h8000_0004;
   localparam logic [31:0] EXC_VECTOR = 32'h8000_0008;
   localparam logic [31:0] NOP_WORD   = 32'h0000_0000;

   typedef enum logic [2:0] {
      PCSEL_SEQ,
      PCSEL_BR,
      PCSEL_EXC,
      PCSEL_JR,
      PCSEL_J,
      PCSEL_IRQ,
      PCSEL_HOLD
   } pcsel_e;

   function automatic logic is_redirect(input pcsel_e sel);
      return (sel != PCSEL_SEQ) && (sel != PCSEL_HOLD);
   endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux for the fetch stage.
module pc_next_sel
   import mips_pkg::*;
#(
   parameter logic [31:0] IRQ_VEC = IRQ_VECTOR,
   parameter logic [31:0] EXC_VEC = EXC_VECTOR
) (
   input  logic [31:0] addr,
   input  logic [3:0]  ifid_pc4_hi,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        exception,
   input  logic        jumpreg,
   input  logic [31:0] jumpreg_target,
   input  logic        jump,
   input  logic [25:0] jump_target,
   input  logic        irq,
   output pcsel_e      sel,
   output logic [31:0] next_pc
);

   always_comb begin
      sel     = PCSEL_SEQ;
      next_pc = addr + 32'd4;
      if (branch_taken) begin
         sel     = PCSEL_BR;
         next_pc = branch_target;
      end else if (exception) begin
         sel     = PCSEL_EXC;
         next_pc = EXC_VEC;
      end else if (jumpreg && !stall) begin
         // user code cannot raise the kernel bit through a register jump
         sel     = PCSEL_JR;
         next_pc = {jumpreg_target[31] & addr[31], jumpreg_target[30:0]};
      end else if (jump && !stall) begin
         sel     = PCSEL_J;
         next_pc = {ifid_pc4_hi, jump_target, 2'b00};
      end else if (irq && !addr[31] && !stall) begin
         sel     = PCSEL_IRQ;
         next_pc = IRQ_VEC;
      end else if (stall) begin
         sel     = PCSEL_HOLD;
         next_pc = addr;
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, IF/ID register, EPC capture.
// Optional IF_PERF_CNT_EN adds Fetch_Count / Stall_Count outputs.
module if_fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RST_PC  = RESET_PC,
   parameter logic [31:0] IRQ_VEC = IRQ_VECTOR,
   parameter logic [31:0] EXC_VEC = EXC_VECTOR,
   parameter logic [31:0] NOP     = NOP_WORD
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instruction,
   input  logic        IF_Stall,
   input  logic        IF_Flush,
   input  logic        Branch_Taken,
   input  logic [31:0] Branch_Target,
   input  logic        Jump,
   input  logic [25:0] Jump_Target,
   input  logic        JumpReg,
   input  logic [31:0] JumpReg_Target,
   input  logic        Exception,
   input  logic        IRQ,
`ifdef IF_PERF_CNT_EN
   output logic [31:0] Fetch_Count,
   output logic [31:0] Stall_Count,
`endif
   output logic [31:0] Address,
   output logic [31:0] IFID_Instruction,
   output logic [31:0] IFID_PC_plus4,
   output logic        IFID_Valid,
   output logic        Irq_Taken,
   output logic [31:0] EPC
);

   logic [31:0] pc_q, pc_d, ins_q, ins_d, pc4_q, pc4_d, epc_q, epc_d;
   logic        vld_q, vld_d, irq_tk_q, irq_tk_d;
   logic [31:0] next_pc, seq_pc;
   logic        squash, load;
   pcsel_e      sel;

   pc_next_sel #(.IRQ_VEC(IRQ_VEC), .EXC_VEC(EXC_VEC)) u_sel (
      .addr           (pc_q),
      .ifid_pc4_hi    (pc4_q[31:28]),
      .stall          (IF_Stall),
      .branch_taken   (Branch_Taken),
      .branch_target  (Branch_Target),
      .exception      (Exception),
      .jumpreg        (JumpReg),
      .jumpreg_target (JumpReg_Target),
      .jump           (Jump),
      .jump_target    (Jump_Target),
      .irq            (IRQ),
      .sel            (sel),
      .next_pc        (next_pc)
   );

   assign seq_pc = pc_q + 32'd4;
   assign squash = is_redirect(sel) || IF_Flush;
   assign load   = (sel != PCSEL_HOLD);

   always_comb begin
      pc_d     = next_pc;
      ins_d    = ins_q;
      pc4_d    = pc4_q;
      vld_d    = vld_q;
      epc_d    = epc_q;
      irq_tk_d = (sel == PCSEL_IRQ);
      // flush wins over stall, so a squash rewrites IF/ID even while PC holds
      if (squash) begin
         ins_d = NOP;
         pc4_d = seq_pc;
         vld_d = 1'b0;
      end else if (load) begin
         ins_d = Instruction;
         pc4_d = seq_pc;
         vld_d = 1'b1;
      end
      if (sel == PCSEL_EXC)      epc_d = pc4_q;
      else if (sel == PCSEL_IRQ) epc_d = pc_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q     <= RST_PC;
         ins_q    <= NOP;
         pc4_q    <= '0;
         vld_q    <= 1'b0;
         epc_q    <= '0;
         irq_tk_q <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         ins_q    <= ins_d;
         pc4_q    <= pc4_d;
         vld_q    <= vld_d;
         epc_q    <= epc_d;
         irq_tk_q <= irq_tk_d;
      end
   end

`ifdef IF_PERF_CNT_EN
   logic [31:0] fcnt_q, fcnt_d, scnt_q, scnt_d;

   always_comb begin
      fcnt_d = fcnt_q + {31'd0, (load && !squash)};
      scnt_d = scnt_q + {31'd0, (sel == PCSEL_HOLD)};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fcnt_q <= '0;
         scnt_q <= '0;
      end else begin
         fcnt_q <= fcnt_d;
         scnt_q <= scnt_d;
      end
   end

   assign Fetch_Count = fcnt_q;
   assign Stall_Count = scnt_q;
`endif

   assign Address          = pc_q;
   assign IFID_Instruction = ins_q;
   assign IFID_PC_plus4    = pc4_q;
   assign IFID_Valid       = vld_q;
   assign Irq_Taken        = irq_tk_q;
   assign EPC              = epc_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed plus random check of if_fetch_stage against a behavioural fetch model.
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Instruction;
   logic        IF_Stall, IF_Flush, Branch_Taken, Jump, JumpReg, Exception, IRQ;
   logic [31:0] Branch_Target, JumpReg_Target;
   logic [25:0] Jump_Target;
   logic [31:0] Address, IFID_Instruction, IFID_PC_plus4, EPC;
   logic        IFID_Valid, Irq_Taken;
`ifdef IF_PERF_CNT_EN
   logic [31:0] Fetch_Count, Stall_Count;
`endif

   logic [31:0] rom [256];
   int total = 0;
   int bad   = 0;

   // model state
   logic [31:0] m_pc, m_ins, m_pc4, m_epc, m_fc, m_sc;
   logic        m_v, m_it;

   if_fetch_stage dut (
      .clk(clk), .reset(reset), .Instruction(Instruction),
      .IF_Stall(IF_Stall), .IF_Flush(IF_Flush),
      .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target),
      .Jump(Jump), .Jump_Target(Jump_Target),
      .JumpReg(JumpReg), .JumpReg_Target(JumpReg_Target),
      .Exception(Exception), .IRQ(IRQ),
`ifdef IF_PERF_CNT_EN
      .Fetch_Count(Fetch_Count), .Stall_Count(Stall_Count),
`endif
      .Address(Address), .IFID_Instruction(IFID_Instruction),
      .IFID_PC_plus4(IFID_PC_plus4), .IFID_Valid(IFID_Valid),
      .Irq_Taken(Irq_Taken), .EPC(EPC)
   );

   always #5 clk = ~clk;
   assign Instruction = rom[Address[9:2]];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_all();
      chk("addr", Address, m_pc);
      chk("ifid_ins", IFID_Instruction, m_ins);
      chk("ifid_pc4", IFID_PC_plus4, m_pc4);
      chk("ifid_vld", {31'd0, IFID_Valid}, {31'd0, m_v});
      chk("irq_tk", {31'd0, Irq_Taken}, {31'd0, m_it});
      chk("epc", EPC, m_epc);
`ifdef IF_PERF_CNT_EN
      chk("fcnt", Fetch_Count, m_fc);
      chk("scnt", Stall_Count, m_sc);
`endif
   endtask

   task automatic idle();
      IF_Stall = 0; IF_Flush = 0; Branch_Taken = 0; Jump = 0; JumpReg = 0;
      Exception = 0; IRQ = 0;
   endtask

   // One clock: predict from the fetch rules, advance, compare.
   task automatic cycle();
      logic [31:0] n_pc, n_ins, n_pc4, n_epc, n_fc, n_sc;
      logic        n_v, n_it, redir, hold, kern;
      n_pc = m_pc; n_ins = m_ins; n_pc4 = m_pc4; n_v = m_v; n_epc = m_epc;
      n_fc = m_fc; n_sc = m_sc; n_it = 0; redir = 1; kern = m_pc[31];
      if (Branch_Taken) n_pc = Branch_Target;
      else if (Exception) begin n_pc = 32'h8000_0008; n_epc = m_pc4; end
      else if (!IF_Stall && JumpReg) n_pc = {JumpReg_Target[31] & kern, JumpReg_Target[30:0]};
      else if (!IF_Stall && Jump) n_pc = {m_pc4[31:28], Jump_Target, 2'b00};
      else if (!IF_Stall && IRQ && !kern) begin
         n_pc = 32'h8000_0004; n_epc = m_pc; n_it = 1;
      end else redir = 0;
      hold = !redir && IF_Stall;
      if (!redir && !hold) n_pc = m_pc + 32'd4;
      if (redir || IF_Flush) begin
         n_ins = 32'h0; n_pc4 = m_pc + 32'd4; n_v = 0;
      end else if (!hold) begin
         n_ins = rom[m_pc[9:2]]; n_pc4 = m_pc + 32'd4; n_v = 1; n_fc = m_fc + 1;
      end
      if (hold) n_sc = m_sc + 1;
      @(posedge clk); #1;
      m_pc = n_pc; m_ins = n_ins; m_pc4 = n_pc4; m_v = n_v; m_epc = n_epc;
      m_it = n_it; m_fc = n_fc; m_sc = n_sc;
      chk_all();
   endtask

   task automatic branch_to(input logic [31:0] t);
      idle(); Branch_Taken = 1; Branch_Target = t; cycle(); idle();
   endtask

   initial begin
      logic [31:0] r;
      for (int i = 0; i < 256; i++) rom[i] = $urandom;
      idle(); Branch_Target = 0; Jump_Target = 0; JumpReg_Target = 0;
      reset = 0;
      m_pc = 32'h8000_0000; m_ins = 0; m_pc4 = 0; m_v = 0; m_epc = 0; m_it = 0;
      m_fc = 0; m_sc = 0;
      #12;
      chk("rst_addr", Address, 32'h8000_0000);
      chk("rst_vld", {31'd0, IFID_Valid}, 32'd0);
      chk_all();
      reset = 1;

      cycle(); chk("seq1", Address, 32'h8000_0004);
      chk("seq1_vld", {31'd0, IFID_Valid}, 32'd1);
      cycle(); chk("seq2", Address, 32'h8000_0008);

      // branch beats jump in the same cycle
      Branch_Taken = 1; Branch_Target = 32'h40; Jump = 1; Jump_Target = 26'h3FF;
      cycle(); idle();
      chk("br_addr", Address, 32'h40);
      chk("br_vld", {31'd0, IFID_Valid}, 32'd0);

      branch_to(32'h100);
      IF_Stall = 1; cycle(); cycle();
      chk("stall_hold", Address, 32'h100);
      idle(); cycle(); chk("stall_rel", Address, 32'h104);

      branch_to(32'h80);
      IRQ = 1; cycle();
      chk("irq_addr", Address, 32'h8000_0004);
      chk("irq_epc", EPC, 32'h80);
      chk("irq_pulse", {31'd0, Irq_Taken}, 32'd1);
      cycle(); cycle();
      chk("irq_mask", {31'd0, Irq_Taken}, 32'd0);
      idle();

      branch_to(32'h200);
      IRQ = 1; IF_Stall = 1; cycle(); cycle();
      chk("irq_stall", {31'd0, Irq_Taken}, 32'd0);
      IF_Stall = 0; cycle();
      chk("irq_defer", EPC, 32'h200);
      idle();

      branch_to(32'h28); cycle();
      Exception = 1; IF_Stall = 1; cycle(); idle();
      chk("exc_addr", Address, 32'h8000_0008);
      chk("exc_epc", EPC, 32'h2C);

      branch_to(32'h300);
      JumpReg = 1; JumpReg_Target = 32'h8000_1000; cycle(); idle();
      chk("jr_user", Address, 32'h0000_1000);

      branch_to(32'h8000_009C); cycle();
      Jump = 1; Jump_Target = 26'h3; cycle(); idle();
      chk("j_kern", Address, 32'h8000_000C);

      branch_to(32'hFFFF_FFFC); cycle();
      chk("wrap", Address, 32'h0);

      IF_Stall = 1; IF_Flush = 1; cycle(); idle();
      chk("flush_stall", {31'd0, IFID_Valid}, 32'd0);

      for (int n = 0; n < 600; n++) begin
         idle();
         Branch_Taken = ($urandom % 100) < 6;
         Exception    = ($urandom % 100) < 4;
         JumpReg      = ($urandom % 100) < 8;
         Jump         = ($urandom % 100) < 8;
         IRQ          = ($urandom % 100) < 25;
         IF_Stall     = ($urandom % 100) < 20;
         IF_Flush     = ($urandom % 100) < 6;
         r = $urandom; Branch_Target = r & 32'hFFFF_FFFC;
         r = $urandom; JumpReg_Target = r & 32'hFFFF_FFFC;
         r = $urandom; Jump_Target = r[25:0];
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
